lfsr_shift_register: RTL
========================

Name: lfsr_shift_register

Overview:
- Parametrised, multi-mode state register for the LFSR datapath.
- Holds an nbits-wide value and updates it with one of eight operations: hold, parallel load, shift, rotate, LFSR step, clear or seed load.
- Operations run either as single enabled steps or as a counted burst under a start/busy/done handshake.
- Sits between the host control logic and the LFSR output taps.

Parameters:
- nbits, 8, register width; must be 2 or more.
- TAPS, 8'hB8 (nbits wide), Fibonacci feedback mask; bit i set means q[i] feeds the XOR.
- SEED, 8'h01 (nbits wide), reset and seed value; must be nonzero.
- CW, 8, width of the burst step count.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- en  input  1  single-step enable; sampled in IDLE only.
- mode  input  3  operation select.
- d  input  nbits  parallel load data.
- sin  input  1  serial input for shift modes.
- start  input  1  burst request.
- steps  input  CW  burst length, captured with start.
- busy  output  1  high while in RUN or DONE.
- done  output  1  one-cycle pulse at burst completion.
- q  output  nbits  register value.
- sout  output  1  bit leaving q under the active mode (combinational).

Behaviour:
- Reset (rst=0, asynchronous): q=SEED, FSM=IDLE, busy=0, done=0, step counter=0, captured mode=0.
- Mode encoding (op applied at one clock edge):
  - 0 hold.
  - 1 q<=d.
  - 2 shift left: q<={q[nbits-2:0],sin}.
  - 3 shift right: q<={sin,q[nbits-1:1]}.
  - 4 rotate left: q<={q[nbits-2:0],q[nbits-1]}.
  - 5 LFSR step: fb=^(q&TAPS), q<={q[nbits-2:0],fb}.
  - 6 clear: q<=0.
  - 7 seed: q<=SEED.
- sout:
  - q[nbits-1] for modes 2, 4 and 5.
  - q[0] for mode 3.
  - 0 otherwise.
  - Uses the captured mode in RUN and the mode input in IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 with steps>0: capture mode and steps, go to RUN; q unchanged on that edge.
  - start=1 with steps=0: go to DONE; q unchanged.
  - start=0 with en=1: apply the mode op once.
  - start has priority over en in the same cycle.
- RUN:
  - Each edge applies the captured op and decrements the counter.
  - The edge that applies the final step (counter==1) moves to DONE.
  - en, mode, start and steps are ignored.
  - sin is still sampled each step.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE; start is ignored.
- Burst of N steps: q changes at N consecutive edges after the start edge; done is high the cycle after the last update.
- Reset mid-burst aborts immediately to the reset state; no done pulse is produced.
- Maximum burst is 2^CW-1 steps; the counter never wraps.

Optional Feature:
- Macro LFSR_LOCKUP_GUARD_EN.
- Defined: a mode-5 step with q==0 loads SEED instead of computing fb. This applies to both single steps and bursts.
- Not defined: q==0 under mode 5 stays 0, the all-zero lockup.

Test Plan:
- Reset and LFSR single steps:
  - Stimulus: nbits=8, TAPS=8'hB8, SEED=8'h01; assert rst=0 mid-cycle, release, then en=1, mode=5 for 4 cycles.
  - Response: q=8'h01 immediately on reset; then q=02,04,08,11.
- Parallel load then shift:
  - Stimulus: mode=1, d=8'hA5, en=1; then mode=3, sin=1, en=1.
  - Response: q=A5 then q=D2; sout=1 during the shift cycle.
- Counted burst:
  - Stimulus: q=01, start=1, steps=4, mode=5; hold en=1 and toggle mode throughout.
  - Response: busy high 5 cycles; q=11 after the 4th step edge; done pulses exactly once; en and mode have no effect.
- Zero-length burst and busy start:
  - Stimulus: start with steps=0; then a burst with start re-asserted during RUN.
  - Response: zero-length gives done next cycle with q unchanged; the re-asserted start is ignored.
- Reset abort:
  - Stimulus: rst=0 during the 2nd step of a steps=10 burst.
  - Response: q=01, busy=0, no done pulse.
- Lockup:
  - Stimulus: mode=6 then mode=5.
  - Response: with LFSR_LOCKUP_GUARD_EN defined, q becomes 01; without it, q stays 00.

Source files
------------

// File: rtl/lfsr_shift_register.sv
// ============================================================================
// Module   : lfsr_shift_register
// Purpose  : Multi-mode nbits state register (hold/load/shift/rotate/LFSR/
//            clear/seed) with single-step and counted-burst operation.
//            Optional macro LFSR_LOCKUP_GUARD_EN reseeds an all-zero LFSR step.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lfsr_shift_register #(
  parameter int                 nbits = 8,
  parameter logic [nbits-1:0]   TAPS  = 8'hB8,
  parameter logic [nbits-1:0]   SEED  = 8'h01,
  parameter int                 CW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [nbits-1:0] d,
  input  logic             sin,
  input  logic             start,
  input  logic [CW-1:0]    steps,
  output logic             busy,
  output logic             done,
  output logic [nbits-1:0] q,
  output logic             sout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic [nbits-1:0] q_q, q_d;
  logic [2:0]       act_mode;
  logic [nbits-1:0] op_result;

  function automatic logic [nbits-1:0] apply_op(input logic [2:0] m,
                                                input logic [nbits-1:0] v,
                                                input logic s);
    logic [nbits-1:0] r;
    r = v;
    case (m)
      3'd1: r = d;
      3'd2: r = {v[nbits-2:0], s};
      3'd3: r = {s, v[nbits-1:1]};
      3'd4: r = {v[nbits-2:0], v[nbits-1]};
      3'd5: begin
`ifdef LFSR_LOCKUP_GUARD_EN
        if (v == '0) r = SEED;
        else         r = {v[nbits-2:0], ^(v & TAPS)};
`else
        r = {v[nbits-2:0], ^(v & TAPS)};
`endif
      end
      3'd6: r = '0;
      3'd7: r = SEED;
      default: r = v;
    endcase
    return r;
  endfunction

  // A burst keeps using the mode captured with start, not the live input.
  assign act_mode  = (state_q == RUN) ? mode_q : mode;
  assign op_result = apply_op(act_mode, q_q, sin);

  always_comb begin
    sout = 1'b0;
    case (act_mode)
      3'd2, 3'd4, 3'd5: sout = q_q[nbits-1];
      3'd3:             sout = q_q[0];
      default:          sout = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    q_d     = q_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (steps != '0) begin
            state_d = RUN;
            cnt_d   = steps;
            mode_d  = mode;
          end else begin
            state_d = DONE;
          end
        end else if (en) begin
          q_d = op_result;
        end
      end
      RUN: begin
        q_d   = op_result;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 3'd0;
      q_q     <= SEED;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      q_q     <= q_d;
    end
  end

  assign q    = q_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

`default_nettype wire
